apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 163 ++++++++++++++++
 tb/tb_apb_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB master: turns a single-beat CPU request into an APB SETUP/ACCESS transfer.
// Latency: cpu_done pulses 3 cycles after the request cycle, plus one cycle per wait state.
// Backpressure: cpu_ready is high only in IDLE; requests are sampled only then, and pready stretches ACCESS.
module apb_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic                  pclk,
   input  logic                  presetn,
   // CPU side
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   input  logic [3:0]            cpu_wstrb,
   output logic                  cpu_ready,
   output logic                  cpu_done,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_err,
   // APB side
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [DATA_WIDTH-1:0] pdata,
   input  logic [DATA_WIDTH-1:0] prdata,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [3:0]            pstb,
   input  logic                  pready,
   input  logic                  perr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   // Timeout threshold in counter width; only meaningful when TIMEOUT != 0.
   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
   logic                  pwrite_q, pwrite_d;
   logic [3:0]            pstb_q, pstb_d;
   logic                  psel_q, psel_d;
   logic                  penable_q, penable_d;
   logic                  cpu_done_q, cpu_done_d;
   logic                  cpu_err_q, cpu_err_d;
   logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [15:0]           wait_cnt_q, wait_cnt_d;
   logic                  timed_out;

   // The counter has reached the limit while the responder still stalls.
   assign timed_out = (TIMEOUT != 0) && (wait_cnt_q == TMO);

   // Next-state and registered-output decode; completion status defaults to 0 so it only shows in the done cycle.
   always_comb begin
      state_d     = state_q;
      paddr_d     = paddr_q;
      pdata_d     = pdata_q;
      pwrite_d    = pwrite_q;
      pstb_d      = pstb_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      wait_cnt_d  = wait_cnt_q;
      cpu_done_d  = 1'b0;
      cpu_err_d   = 1'b0;
      cpu_rdata_d = '0;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               state_d    = SETUP;
               paddr_d    = cpu_addr;
               pdata_d    = cpu_wdata;
               pwrite_d   = cpu_we;
               pstb_d     = cpu_we ? cpu_wstrb : 4'b0000;
               psel_d     = 1'b1;
               penable_d  = 1'b0;
               wait_cnt_d = '0;
            end
         end

         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end

         ACCESS: begin
            if (pready) begin
               // Responder completion wins over a coincident timeout.
               state_d     = IDLE;
               psel_d      = 1'b0;
               penable_d   = 1'b0;
               cpu_done_d  = 1'b1;
               cpu_err_d   = perr;
               cpu_rdata_d = pwrite_q ? '0 : prdata;
            end else begin
               if (wait_cnt_q != 16'hFFFF) begin
                  wait_cnt_d = wait_cnt_q + 16'd1;
               end
               if (timed_out) begin
                  state_d     = IDLE;
                  psel_d      = 1'b0;
                  penable_d   = 1'b0;
                  cpu_done_d  = 1'b1;
                  cpu_err_d   = 1'b1;
                  cpu_rdata_d = '0;
               end
            end
         end

         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset aborts any transfer in flight.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= IDLE;
         paddr_q     <= '0;
         pdata_q     <= '0;
         pwrite_q    <= 1'b0;
         pstb_q      <= 4'b0000;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         wait_cnt_q  <= '0;
         cpu_done_q  <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         paddr_q     <= paddr_d;
         pdata_q     <= pdata_d;
         pwrite_q    <= pwrite_d;
         pstb_q      <= pstb_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         wait_cnt_q  <= wait_cnt_d;
         cpu_done_q  <= cpu_done_d;
         cpu_err_q   <= cpu_err_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   assign cpu_ready = (state_q == IDLE);
   assign cpu_done  = cpu_done_q;
   assign cpu_err   = cpu_err_q;
   assign cpu_rdata = cpu_rdata_q;
   assign paddr     = paddr_q;
   assign pdata     = pdata_q;
   assign pwrite    = pwrite_q;
   assign pstb      = pstb_q;
   assign psel      = psel_q;
   assign penable   = penable_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with TIMEOUT=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every transfer wait is bounded; a missing cpu_done shows up as a failed check.
module tb_apb_master;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          pclk = 1'b0;
   logic          presetn;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic [3:0]    cpu_wstrb;
   logic          cpu_ready, cpu_done, cpu_err;
   logic [DW-1:0] cpu_rdata;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pdata, prdata;
   logic          psel, penable, pwrite, pready, perr;
   logic [3:0]    pstb;

   int checks = 0;
   int errors = 0;

   always #5 pclk = ~pclk;

   apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
      .pclk(pclk), .presetn(presetn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb),
      .cpu_ready(cpu_ready), .cpu_done(cpu_done),
      .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
      .paddr(paddr), .pdata(pdata), .prdata(prdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .pstb(pstb),
      .pready(pready), .perr(perr)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   // One transfer. Cycle 0 is the request cycle; pready is low for nwait ACCESS
   // cycles then high (for nwait==0 it is also high in SETUP, which must be ignored).
   // Returns in the done cycle, or after a 40-cycle budget with done_cyc = -1.
   task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input int nwait,
                       input logic [31:0] resp_data, input logic resp_err,
                       output int done_cyc, output int psel_n, output int pen_n,
                       output logic [31:0] rdata, output logic err, output int unstable);
      logic [3:0] exp_stb;
      exp_stb  = we ? strb : 4'b0000;
      done_cyc = -1;
      psel_n   = 0;
      pen_n    = 0;
      unstable = 0;
      rdata    = '0;
      err      = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_wstrb = strb;
      pready    = 1'b0;
      perr      = 1'b0;
      step();
      cpu_req = 1'b0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         pready = (cyc >= 2 + nwait) || (nwait == 0);
         prdata = resp_data;
         perr   = resp_err;
         if (psel) begin
            psel_n++;
            if (paddr !== addr || pdata !== wdata || pwrite !== we || pstb !== exp_stb)
               unstable++;
         end
         if (penable) pen_n++;
         if (cpu_done) begin
            done_cyc = cyc;
            rdata    = cpu_rdata;
            err      = cpu_err;
            break;
         end
         step();
      end
      pready = 1'b0;
      perr   = 1'b0;
   endtask

   int          dc, pn, en, un, seen;
   logic [31:0] rd;
   logic        er;
   logic [5:0]  psel_v, done_v;

   initial begin
      presetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
      cpu_wdata = '0; cpu_wstrb = '0; prdata = '0; pready = 1'b0; perr = 1'b0;

      // Reset state
      #12;
      chk_eq("rst_ready",   32'(cpu_ready), 32'd1);
      chk_eq("rst_psel",    32'(psel),      32'd0);
      chk_eq("rst_penable", 32'(penable),   32'd0);
      chk_eq("rst_pwrite",  32'(pwrite),    32'd0);
      chk_eq("rst_paddr",   paddr,          32'd0);
      chk_eq("rst_pdata",   pdata,          32'd0);
      chk_eq("rst_pstb",    32'(pstb),      32'd0);
      chk_eq("rst_done",    32'(cpu_done),  32'd0);
      chk_eq("rst_err",     32'(cpu_err),   32'd0);
      chk_eq("rst_rdata",   cpu_rdata,      32'd0);
      step();
      presetn = 1'b1;
      step();

      // Write, no waits; responder drives junk prdata that must not appear
      xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'hAAAA5555, 1'b0, dc, pn, en, rd, er, un);
      chk_eq("wr_done_cyc", 32'(dc), 32'd3);
      chk_eq("wr_psel_n",   32'(pn), 32'd2);
      chk_eq("wr_pen_n",    32'(en), 32'd1);
      chk_eq("wr_stable",   32'(un), 32'd0);
      chk_eq("wr_err",      32'(er), 32'd0);
      chk_eq("wr_rdata",    rd,      32'd0);
      chk_eq("wr_hold_addr", paddr,  32'h10);
      chk_eq("wr_hold_stb", 32'(pstb), 32'hF);
      step();
      chk_eq("wr_done_pulse", 32'(cpu_done), 32'd0);

      // Read with two wait states
      xfer(1'b0, 32'h20, 32'h0BADF00D, 4'hC, 2, 32'h12345678, 1'b0, dc, pn, en, rd, er, un);
      chk_eq("rd_done_cyc", 32'(dc), 32'd5);
      chk_eq("rd_psel_n",   32'(pn), 32'd4);
      chk_eq("rd_pen_n",    32'(en), 32'd3);
      chk_eq("rd_stable",   32'(un), 32'd0);
      chk_eq("rd_pstb",     32'(pstb), 32'd0);
      chk_eq("rd_rdata",    rd,      32'h12345678);
      chk_eq("rd_err",      32'(er), 32'd0);
      step();

      // Error response on a write
      xfer(1'b1, 32'h24, 32'h00000001, 4'h3, 0, 32'h0, 1'b1, dc, pn, en, rd, er, un);
      chk_eq("er_done_cyc", 32'(dc), 32'd3);
      chk_eq("er_err",      32'(er), 32'd1);
      chk_eq("er_psel",     32'(psel), 32'd0);
      chk_eq("er_ready",    32'(cpu_ready), 32'd1);
      step();
      chk_eq("er_err_clr",  32'(cpu_err), 32'd0);

      // Timeout: 4 counted wait edges, terminated on the fifth ACCESS edge
      xfer(1'b0, 32'h28, 32'h0, 4'h0, 1000, 32'hCAFEF00D, 1'b0, dc, pn, en, rd, er, un);
      chk_eq("to_done_cyc", 32'(dc), 32'd7);
      chk_eq("to_psel_n",   32'(pn), 32'd6);
      chk_eq("to_err",      32'(er), 32'd1);
      chk_eq("to_rdata",    rd,      32'd0);
      chk_eq("to_psel",     32'(psel), 32'd0);
      chk_eq("to_penable",  32'(penable), 32'd0);
      step();

      // pready arrives on the same edge the timeout would fire: responder wins
      xfer(1'b0, 32'h2C, 32'h0, 4'h0, 4, 32'h5A5A1234, 1'b0, dc, pn, en, rd, er, un);
      chk_eq("tie_done_cyc", 32'(dc), 32'd7);
      chk_eq("tie_err",      32'(er), 32'd0);
      chk_eq("tie_rdata",    rd,      32'h5A5A1234);
      step();

      // Reset pulsed during ACCESS
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h30; pready = 1'b0;
      step();
      cpu_req = 1'b0;
      step();
      step();
      chk_eq("mr_in_access", 32'(penable), 32'd1);
      presetn = 1'b0;
      #1;
      chk_eq("mr_psel",    32'(psel),    32'd0);
      chk_eq("mr_penable", 32'(penable), 32'd0);
      chk_eq("mr_paddr",   paddr,        32'd0);
      step();
      presetn = 1'b1;
      pready  = 1'b1;
      seen    = 0;
      for (int i = 0; i < 6; i++) begin
         if (cpu_done || psel) seen++;
         step();
      end
      pready = 1'b0;
      chk_eq("mr_no_done", 32'(seen), 32'd0);
      xfer(1'b1, 32'h44, 32'h11223344, 4'h5, 0, 32'h0, 1'b0, dc, pn, en, rd, er, un);
      chk_eq("mr_next_cyc", 32'(dc), 32'd3);
      chk_eq("mr_next_err", 32'(er), 32'd0);
      step();

      // Back-to-back writes with cpu_req held high
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h50; cpu_wdata = 32'hA0A0A0A0;
      cpu_wstrb = 4'hF; pready = 1'b1;
      psel_v = '0; done_v = '0;
      for (int c = 1; c <= 6; c++) begin
         step();
         psel_v[c-1] = psel;
         done_v[c-1] = cpu_done;
         if (c == 3) begin
            chk_eq("b2b_ready", 32'(cpu_ready), 32'd1);
            cpu_addr = 32'h54; cpu_wdata = 32'hB1B1B1B1; cpu_wstrb = 4'h9;
         end
         if (c == 4) begin
            cpu_req = 1'b0;
            chk_eq("b2b_addr2", paddr, 32'h54);
            chk_eq("b2b_stb2",  32'(pstb), 32'h9);
         end
      end
      pready = 1'b0;
      chk_eq("b2b_psel_seq", 32'(psel_v), 32'b011011);
      chk_eq("b2b_done_seq", 32'(done_v), 32'b100100);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
